// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the load/store path.
// Optional fetch anti-starvation guard: define ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no transaction outstanding, grants may be issued
// BUSY  | one access in flight, lat_cnt counts down to the response cycle
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be in 1..15");
  end

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic        owner;
  logic        owner_we;
  logic [3:0]  lat_cnt;
  logic        force_if;
  logic        rsp;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;
  assign force_if = (starve_cnt == STARVE_LIM) & if_req & dm_req;
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (state == IDLE) begin
      if (dm_req && !force_if) dm_gnt = 1'b1;
      else if (if_req)         if_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // The response cycle is the terminal count of the latency down-counter.
  assign rsp = (state == BUSY) && (lat_cnt == 4'd1);

  always_comb begin
    if_rvalid = rsp & ~owner;
    dm_rvalid = rsp & owner;
    if_rdata  = if_rvalid ? mem_rdata : 32'd0;
    dm_rdata  = (dm_rvalid && !owner_we) ? mem_rdata : 32'd0;
  end

  assign stall = (state == BUSY) | (if_req & ~if_gnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      owner_we <= 1'b0;
      lat_cnt  <= 4'd0;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_en) begin
            state    <= BUSY;
            owner    <= dm_gnt;
            owner_we <= dm_gnt & dm_we;
            lat_cnt  <= LAT_LOAD;
          end
        end
        BUSY: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef ARB_STARVE_GUARD_EN
      if (if_gnt) begin
        starve_cnt <= 4'd0;
      end else if (dm_gnt) begin
        if (!if_req)                   starve_cnt <= 4'd0;
        else if (starve_cnt != 4'hF)   starve_cnt <= starve_cnt + 4'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// starvation and MEM_LAT=1 back-to-back sequences.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, stall;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  logic        l1_if_req;
  logic [31:0] l1_if_addr, l1_mem_rdata;
  logic        l1_if_gnt, l1_if_rvalid, l1_dm_gnt, l1_dm_rvalid, l1_mem_en, l1_mem_we, l1_stall;
  logic [31:0] l1_if_rdata, l1_dm_rdata, l1_mem_addr, l1_mem_wdata;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) dut_l1 (
    .clk(clk), .reset(reset),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt),
    .if_rvalid(l1_if_rvalid), .if_rdata(l1_if_rdata),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'd0), .dm_wdata(32'd0),
    .dm_gnt(l1_dm_gnt), .dm_rvalid(l1_dm_rvalid), .dm_rdata(l1_dm_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .stall(l1_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, ir;
    logic [31:0] ia;
    logic        dr, dw;
    logic [31:0] da, dd, mr;
    logic        eig, edg, eiv, edv;
    logic [31:0] eir, edr;
    logic        eme, emw;
    logic [31:0] ema, emd;
    logic        est;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string n, input logic rst, ir, input logic [31:0] ia,
                     input logic dr, dw, input logic [31:0] da, dd, mr,
                     input logic eig, edg, eiv, edv, input logic [31:0] eir, edr,
                     input logic eme, emw, input logic [31:0] ema, emd, input logic est);
    vec_t v;
    v.name = n; v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw;
    v.da = da; v.dd = dd; v.mr = mr; v.eig = eig; v.edg = edg; v.eiv = eiv;
    v.edv = edv; v.eir = eir; v.edr = edr; v.eme = eme; v.emw = emw;
    v.ema = ema; v.emd = emd; v.est = est;
    vq.push_back(v);
  endtask

  task automatic check_vec(input vec_t v);
    n_vec++;
    if (!(if_gnt === v.eig && dm_gnt === v.edg && if_rvalid === v.eiv && dm_rvalid === v.edv &&
          if_rdata === v.eir && dm_rdata === v.edr && mem_en === v.eme && mem_we === v.emw &&
          mem_addr === v.ema && mem_wdata === v.emd && stall === v.est)) begin
      n_err++;
      $display("FAIL %s: got ig=%b dg=%b iv=%b dv=%b ir=%h dr=%h me=%b mw=%b ma=%h md=%h st=%b; want ig=%b dg=%b iv=%b dv=%b ir=%h dr=%h me=%b mw=%b ma=%h md=%h st=%b",
               v.name, if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_rdata, dm_rdata, mem_en, mem_we,
               mem_addr, mem_wdata, stall, v.eig, v.edg, v.eiv, v.edv, v.eir, v.edr, v.eme,
               v.emw, v.ema, v.emd, v.est);
    end
  endtask

  logic exp_if_pat [5];

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    l1_if_req = 1'b0; l1_if_addr = '0; l1_mem_rdata = '0;

    //   name        rst ir ia           dr dw da           dd            mr              ig dg iv dv ir            dr            me mw ma           md            st
    add("reset",     1, 0, 32'h0,      0, 0, 32'h0,     32'h0,        32'h0,          0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,     32'h0,        0);
    add("if_issue",  0, 1, 32'h10,     0, 0, 32'h0,     32'h0,        32'h0,          1, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h10,    32'h0,        0);
    add("if_busy",   0, 0, 32'h0,      0, 0, 32'h0,     32'h0,        32'h1111,       0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,     32'h0,        1);
    add("if_resp",   0, 0, 32'h0,      0, 0, 32'h0,     32'h0,        32'hAAAA0001,   0, 0, 1, 0, 32'hAAAA0001, 32'h0,        0, 0, 32'h0,     32'h0,        1);
    add("dm_wins",   0, 1, 32'h20,     1, 0, 32'h100,   32'h0,        32'h2222,       0, 1, 0, 0, 32'h0,        32'h0,        1, 0, 32'h100,   32'h0,        1);
    add("dm_busy",   0, 1, 32'h20,     0, 0, 32'h0,     32'h0,        32'h3333,       0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,     32'h0,        1);
    add("dm_resp",   0, 1, 32'h20,     0, 0, 32'h0,     32'h0,        32'hBBBB0002,   0, 0, 0, 1, 32'h0,        32'hBBBB0002, 0, 0, 32'h0,     32'h0,        1);
    add("if_after",  0, 1, 32'h20,     0, 0, 32'h0,     32'h0,        32'h0,          1, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h20,    32'h0,        0);
    add("if_busy2",  0, 0, 32'h0,      0, 0, 32'h0,     32'h0,        32'h4444,       0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,     32'h0,        1);
    add("if_resp2",  0, 0, 32'h0,      0, 0, 32'h0,     32'h0,        32'hCCCC0003,   0, 0, 1, 0, 32'hCCCC0003, 32'h0,        0, 0, 32'h0,     32'h0,        1);
    add("store",     0, 0, 32'h0,      1, 1, 32'h40,    32'hDEADBEEF, 32'h0,          0, 1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h40,    32'hDEADBEEF, 0);
    add("st_busy",   0, 0, 32'h0,      0, 0, 32'h0,     32'h0,        32'h7777,       0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,     32'h0,        1);
    add("st_resp",   0, 0, 32'h0,      0, 0, 32'h0,     32'h0,        32'h12345678,   0, 0, 0, 1, 32'h0,        32'h0,        0, 0, 32'h0,     32'h0,        1);
    add("load2",     0, 0, 32'h0,      1, 0, 32'h200,   32'h0,        32'h0,          0, 1, 0, 0, 32'h0,        32'h0,        1, 0, 32'h200,   32'h0,        0);
    add("rst_busy",  1, 0, 32'h0,      0, 0, 32'h0,     32'h0,        32'h5555,       0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,     32'h0,        1);
    add("post_rst",  0, 0, 32'h0,      0, 0, 32'h0,     32'h0,        32'h6666,       0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,     32'h0,        0);
    add("idle",      0, 0, 32'h0,      0, 0, 32'h0,     32'h0,        32'h8888,       0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,     32'h0,        0);

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; if_req = vq[i].ir; if_addr = vq[i].ia;
      dm_req = vq[i].dr; dm_we = vq[i].dw; dm_addr = vq[i].da;
      dm_wdata = vq[i].dd; mem_rdata = vq[i].mr;
      #1;
      check_vec(vq[i]);
    end

    // Both requesters held: grants land every MEM_LAT+1 = 3 cycles.
`ifdef ARB_STARVE_GUARD_EN
    exp_if_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_if_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h30; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
      #1;
      n_vec++;
      if (if_gnt !== exp_if_pat[g] || dm_gnt !== !exp_if_pat[g]) begin
        n_err++;
        $display("FAIL starve_grant%0d: got if_gnt=%b dm_gnt=%b, want if_gnt=%b dm_gnt=%b",
                 g, if_gnt, dm_gnt, exp_if_pat[g], !exp_if_pat[g]);
      end
      @(negedge clk);
      @(negedge clk);
    end
    @(negedge clk);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (3) @(negedge clk);

    // MEM_LAT=1 instance: grant every 2 cycles, rvalid the cycle after each grant.
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      l1_if_req = 1'b1; l1_if_addr = 32'h400 + 32'(k); l1_mem_rdata = 32'h0F00_0000 + 32'(k);
      #1;
      n_vec++;
      if (l1_if_gnt !== (k % 2 == 0) || l1_mem_en !== (k % 2 == 0) ||
          l1_if_rvalid !== (k % 2 == 1) || l1_stall !== (k % 2 == 1) ||
          l1_if_rdata !== ((k % 2 == 1) ? l1_mem_rdata : 32'h0)) begin
        n_err++;
        $display("FAIL lat1_cycle%0d: got gnt=%b en=%b rv=%b st=%b rd=%h, want gnt=%b en=%b rv=%b st=%b",
                 k, l1_if_gnt, l1_mem_en, l1_if_rvalid, l1_stall, l1_if_rdata,
                 (k % 2 == 0), (k % 2 == 0), (k % 2 == 1), (k % 2 == 1));
      end
    end
    @(negedge clk);
    l1_if_req = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
